// File: rtl/nw_vc_pkg.sv
// nw_vc_pkg: shared VC state type and small helpers for the free-VC pool
package nw_vc_pkg;
    typedef enum logic [1:0] {FREE, ALLOCATED, DRAINING} vc_state_t;
    function automatic int popcount(input logic [31:0] v);
        int n;
        n = 0;
        for (int b = 0; b < 32; b++) n += int'(v[b]);
        return n;
    endfunction
    function automatic int class_of(input int vc, input int num_vcs, input int num_classes);
        return vc / (num_vcs / num_classes);
    endfunction
endpackage

// File: rtl/vc_credit_ctr.sv
// vc_credit_ctr: saturating downstream credit counter, loaded to buf_depth on reset
module vc_credit_ctr #(
    parameter int buf_depth = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             inc,
    input  logic                             dec,
    output logic [$clog2(buf_depth+1)-1:0]   count,
    output logic                             full,
    output logic                             err
);
    localparam int cw = $clog2(buf_depth + 1);
    localparam logic [cw-1:0] max_c = cw'(buf_depth);
    logic [cw-1:0] count_q, count_d;
    always_comb begin
        err = (inc && !dec && count_q == max_c) || (dec && !inc && count_q == '0);
        count_d = err ? count_q : (inc && !dec) ? count_q + cw'(1) : (dec && !inc) ? count_q - cw'(1) : count_q;
    end
    always_ff @(posedge clk) count_q <= rst ? max_c : count_d;
    assign count = count_q;
    assign full = count_q == max_c;
endmodule

// File: rtl/vc_class_free_pool.sv
// vc_class_free_pool: per-output-port VC free tracker with credit-gated drain and per-class free counts
module vc_class_free_pool
    import nw_vc_pkg::*;
#(
    parameter int num_vcs          = 4,
    parameter int num_classes      = 2,
    parameter int buf_depth        = 4,
    parameter bit alloc_when_empty = 1'b1
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic [num_vcs-1:0]                                    vc_allocated,
    input  logic                                                  flit_valid,
    input  logic [$clog2(num_vcs)-1:0]                            flit_vc,
    input  logic                                                  flit_tail,
    input  logic                                                  credit_valid,
    input  logic [$clog2(num_vcs)-1:0]                            credit_vc,
    output logic [num_vcs-1:0]                                    vc_free,
    output logic [num_classes*$clog2(num_vcs/num_classes+1)-1:0]  class_free_count,
    output logic [num_vcs*$clog2(buf_depth+1)-1:0]                vc_credits,
    output logic [2:0]                                            err
);
    localparam int vw  = $clog2(num_vcs);
    localparam int vpc = num_vcs / num_classes;
    localparam int fw  = $clog2(vpc + 1);
    localparam int cw  = $clog2(buf_depth + 1);
    vc_state_t state_q [num_vcs];
    vc_state_t state_d [num_vcs];
    logic [2:0] err_q, err_d;
    logic [num_vcs-1:0] inc, dec, tail, full, cerr;
    for (genvar i = 0; i < num_vcs; i++) begin : g_vc
        assign inc[i]  = credit_valid && credit_vc == vw'(i);
        assign dec[i]  = flit_valid && flit_vc == vw'(i);
        assign tail[i] = dec[i] && flit_tail;
        vc_credit_ctr #(.buf_depth(buf_depth)) u_ctr (
            .clk   (clk),
            .rst   (rst),
            .inc   (inc[i]),
            .dec   (dec[i]),
            .count (vc_credits[i*cw +: cw]),
            .full  (full[i]),
            .err   (cerr[i])
        );
    end
    // Drain completion looks at the registered count, so a credit lands one cycle before release.
    always_comb begin
        err_d = err_q | {|cerr, 2'b00};
        for (int v = 0; v < num_vcs; v++) begin
            state_d[v] = state_q[v];
            if (vc_allocated[v]) begin
                if (state_q[v] == FREE) state_d[v] = ALLOCATED;
                else err_d[0] = 1'b1;
            end
            if (tail[v]) begin
                if (state_q[v] == ALLOCATED) state_d[v] = alloc_when_empty ? DRAINING : FREE;
                else err_d[1] = 1'b1;
            end
            if (state_q[v] == DRAINING && full[v]) state_d[v] = FREE;
        end
    end
    always_ff @(posedge clk) begin
        for (int v = 0; v < num_vcs; v++) state_q[v] <= rst ? FREE : state_d[v];
        err_q <= rst ? 3'b000 : err_d;
    end
    always_comb begin
        for (int v = 0; v < num_vcs; v++) vc_free[v] = state_q[v] == FREE;
    end
    always_comb begin
        for (int c = 0; c < num_classes; c++) class_free_count[c*fw +: fw] = fw'(popcount(32'(vc_free[c*vpc +: vpc])));
    end
    assign err = err_q;
endmodule

// File: doc/vc_class_free_pool.md
# vc_class_free_pool

Per-output-port free-VC tracker for the NW router, generalised over VC count, VC classes and downstream buffer depth. It tracks every VC through allocation, packet transfer and downstream drain. A VC is offered again only after its tail flit has left and, optionally, after the downstream FIFO has fully drained, using per-VC credit counters. It sits between the output link (flit/credit traffic) and the VC allocator, and supplies a registered free mask plus per-class free counts.

## Interface
- num_vcs, 4: VCs at this output port.
- num_classes, 2: VC classes. num_vcs must be divisible by num_classes. VC i belongs to class i/(num_vcs/num_classes).
- buf_depth, 4: downstream FIFO depth per VC, which is also the initial credit count.
- alloc_when_empty, 1: 1 = a released VC waits for full credits before becoming free. 0 = freed on tail departure.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- vc_allocated  in  num_vcs  VCs granted by the VC allocator this cycle (any number of bits).
- flit_valid  in  1  flit sent on output link this cycle.
- flit_vc  in  clog2(num_vcs)  binary VC id of the sent flit.
- flit_tail  in  1  sent flit is a tail (single-flit packets set this).
- credit_valid  in  1  downstream credit returned this cycle.
- credit_vc  in  clog2(num_vcs)  binary VC id of the returned credit.
- vc_free  out  num_vcs  registered; bit i = VC i is allocatable.
- class_free_count  out  num_classes*clog2(num_vcs/num_classes+1)  popcount of vc_free per class; class 0 in the LSBs.
- vc_credits  out  num_vcs*clog2(buf_depth+1)  current credit count per VC; VC 0 in the LSBs.
- err  out  3  sticky flags: [0] alloc of a non-FREE VC, [1] tail on a non-ALLOCATED VC, [2] credit overflow or underflow.

## Operation
- Each VC has a state: FREE, ALLOCATED or DRAINING. vc_free[i] = (state==FREE).
- FREE → ALLOCATED: vc_allocated[i]=1.
- ALLOCATED → FREE: flit_valid && flit_tail && flit_vc==i, when alloc_when_empty=0.
- ALLOCATED → DRAINING: the same tail event, when alloc_when_empty=1. DRAINING is always entered, even if credits are already full.
- DRAINING → FREE: the registered credit count equals buf_depth.
- Credits:
  - flit_valid for VC i: credit count −1.
  - credit_valid for VC i: credit count +1.
  - Both in the same cycle for the same VC: count unchanged.
  - A decrement at 0 or an increment at buf_depth: count holds and err[2] sets.
- Illegal events: vc_allocated on a non-FREE VC is ignored and sets err[0]. A tail on a non-ALLOCATED VC is ignored and sets err[1].
- A flit on a VC that is not ALLOCATED still consumes a credit.
- A VC allocated in the same cycle as its own tail departure cannot occur legally, because the VC is not FREE. It is handled by the illegal-event rules above.
- Reset: all VCs FREE, all credits = buf_depth, err = 0, vc_free all ones, class_free_count = num_vcs/num_classes for every class.
- Reset asserted mid-packet or mid-drain discards all state on that edge; no errors are flagged.

## Timing
- Allocation: vc_allocated in cycle t → vc_free[i]=0 from t+1.
- Release with alloc_when_empty=0: tail in cycle t → vc_free[i]=1 from t+1.
- Release with alloc_when_empty=1: tail in cycle t → DRAINING at t+1. The earliest vc_free[i]=1 is t+2, and only if credits are full at t+1.
- Credit: credit_valid in cycle t → vc_credits updated at t+1 → drain completion visible at t+2.
- class_free_count is combinational from registered vc_free, so it has the same cycle as vc_free. No combinational input-to-output paths.

## Structure
- Shared package nw_vc_pkg holds:
  - the vc_state_t enum {FREE, ALLOCATED, DRAINING};
  - function popcount;
  - function class_of(vc, num_vcs, num_classes).
- Sub-module vc_credit_ctr: one instance per VC via generate. It takes inc, dec and load-on-reset, and outputs count, full, and error. It is parametrised on buf_depth.
- The top level holds the per-VC state FSMs, the error registers and the class popcount.

## Test plan
- Reset then idle: vc_free=4'b1111, class_free_count={2,2}, every vc_credits=4, err=0.
- Allocate VC1; send 3 flits on VC1 with the tail on the 3rd, and no credits returned (alloc_when_empty=1). Expect:
  - credits go 4→1;
  - VC1 DRAINING after the tail;
  - 3 credits returned on consecutive cycles;
  - vc_free[1]=1 exactly 2 cycles after the last credit.
- Same sequence with alloc_when_empty=0: vc_free[1]=1 the cycle after the tail, while credits are still 1.
- Simultaneous flit and credit on VC2 at credits=2: count stays 2. A credit at 4 → count stays 4 and err[2]=1, sticky until rst.
- vc_allocated=4'b0011 in one cycle: next cycle vc_free=4'b1100 and class_free_count={2,0}. Re-allocating VC0 sets err[0] with no state change.
- Assert rst while VC3 is DRAINING with credits=1: next cycle VC3 is FREE, credits=4, err=0.
